// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - decode-stage hazard scoreboard: pending GPR/HI/LO writes, MDU busy counter, stall
module id_hazard_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NREG       = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int MDU_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_rena,
    input  logic              id_rt_rena,
    input  logic              id_rf_wena,
    input  logic [ADDR_W-1:0] id_rf_waddr,
    input  logic              id_hi_rena,
    input  logic              id_lo_rena,
    input  logic              id_hi_wena,
    input  logic              id_lo_wena,
    input  logic              id_mdu_start,
    input  logic              flush,
    output logic              stall,
    output logic [2:0]        stall_cause,
    output logic              mdu_busy,
    output logic [NREG-1:0]   pending_mask,
    output logic [31:0]       stall_cycles
);

    localparam int CNT_W = 6;

    logic [PIPE_DEPTH-1:0] v_rf_q, v_rf_d;
    logic [PIPE_DEPTH-1:0] v_hi_q, v_hi_d;
    logic [PIPE_DEPTH-1:0] v_lo_q, v_lo_d;
    logic [ADDR_W-1:0]     waddr_q [PIPE_DEPTH];
    logic [ADDR_W-1:0]     waddr_d [PIPE_DEPTH];
    logic [CNT_W-1:0]      mdu_cnt_q, mdu_cnt_d;
    logic [31:0]           stall_cycles_q, stall_cycles_d;

    logic gpr_raw, hilo_raw, mdu_struct, busy, issue;

    // Hazard detection looks only at state already in flight, so the ID
    // instruction's own destination can never match itself.
    always_comb begin
        gpr_raw      = 1'b0;
        pending_mask = '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
            if (v_rf_q[k]) begin
                pending_mask[waddr_q[k]] = 1'b1;
                if (id_rs_rena && (id_rs != '0) && (id_rs == waddr_q[k])) gpr_raw = 1'b1;
                if (id_rt_rena && (id_rt != '0) && (id_rt == waddr_q[k])) gpr_raw = 1'b1;
            end
        end
        busy        = (mdu_cnt_q != '0);
        hilo_raw    = (id_hi_rena && ((|v_hi_q) || busy)) ||
                      (id_lo_rena && ((|v_lo_q) || busy));
        mdu_struct  = id_mdu_start && busy;
        stall_cause = (id_valid && !flush) ? {mdu_struct, hilo_raw, gpr_raw} : 3'b000;
        stall       = |stall_cause;
        issue       = id_valid && !flush && !stall;
        mdu_busy    = busy;
    end

    // The pipe keeps shifting through stalls and flushes; only entry 0 is gated.
    always_comb begin
        v_rf_d[0]  = issue && id_rf_wena && (id_rf_waddr != '0);
        v_hi_d[0]  = issue && id_hi_wena;
        v_lo_d[0]  = issue && id_lo_wena;
        waddr_d[0] = issue ? id_rf_waddr : '0;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
            v_rf_d[k]  = v_rf_q[k-1];
            v_hi_d[k]  = v_hi_q[k-1];
            v_lo_d[k]  = v_lo_q[k-1];
            waddr_d[k] = waddr_q[k-1];
        end
        if (issue && id_mdu_start) begin
            mdu_cnt_d = CNT_W'(MDU_LAT);
        end else if (busy) begin
            mdu_cnt_d = mdu_cnt_q - 1'b1;
        end else begin
            mdu_cnt_d = mdu_cnt_q;
        end
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_rf_q         <= '0;
            v_hi_q         <= '0;
            v_lo_q         <= '0;
            mdu_cnt_q      <= '0;
            stall_cycles_q <= '0;
            for (int k = 0; k < PIPE_DEPTH; k++) waddr_q[k] <= '0;
        end else begin
            v_rf_q         <= v_rf_d;
            v_hi_q         <= v_hi_d;
            v_lo_q         <= v_lo_d;
            mdu_cnt_q      <= mdu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
            for (int k = 0; k < PIPE_DEPTH; k++) waddr_q[k] <= waddr_d[k];
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule
